// File: rtl/memb_loader_pkg.sv
// Shared types and sizing helpers for the B-operand tile loader.
package memb_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // Zero rows needed to push the last real row through the deepest skew FIFO.
  function automatic int flush_len(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int row_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/memb_loader_if.sv
// Row-input handshake and skewed-FIFO feed between the loader and its neighbours.
interface memb_loader_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BITS_AB-1:0] in_row [DIM];
  logic signed [BITS_AB-1:0] b_out  [DIM];
  logic                      b_en;
  logic                      tile_start;
  logic                      drained;

  modport master (
    output in_valid, in_row,
    input  in_ready, b_out, b_en, tile_start, drained
  );

  modport slave (
    input  in_valid, in_row,
    output in_ready, b_out, b_en, tile_start, drained
  );
endinterface

// File: rtl/memb_bank.sv
// DIM x DIM tile store: one full row written per edge, one row read combinationally.
module memb_bank
  import memb_loader_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [row_w(DIM)-1:0]      i_wr_row,
  input  logic signed [BITS_AB-1:0]  i_wr_data [DIM],
  input  logic [row_w(DIM)-1:0]      i_rd_row,
  output logic signed [BITS_AB-1:0]  o_rd_data [DIM]
);
  logic signed [BITS_AB-1:0] r_mem [DIM][DIM];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < DIM; i++) begin
        r_mem[i_wr_row][i] <= i_wr_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      o_rd_data[i] = r_mem[i_rd_row][i];
    end
  end
endmodule

// File: rtl/memb_loader.sv
// Ping-pong B tile loader: fills one bank while streaming the other into the skewed B FIFOs.
//   state     | meaning
//   ST_IDLE   | b_en low, waiting for a full bank
//   ST_STREAM | b_out holds row rd_row of the read bank
//   ST_FLUSH  | b_en high with zero rows until the skew FIFOs have emptied
module memb_loader
  import memb_loader_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic         clk,
  input  logic         rst,
  memb_loader_if.slave bus
);
  localparam int ROW_W = row_w(DIM);
  localparam int CNT_W = $clog2(flush_len(DIM) + 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(DIM - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(flush_len(DIM) - 1);

  state_e                    r_state, w_state_nxt;
  logic [1:0]                r_full, w_set_full, w_clr_full;
  logic                      r_fill_bank, r_rd_bank;
  logic [ROW_W-1:0]          r_wr_row, r_rd_row, w_rd_row_nxt;
  logic [CNT_W-1:0]          r_flush_cnt, w_flush_cnt_nxt;
  logic                      w_in_ready, w_accept, w_fill_done, w_rd_avail, w_bypass;
  logic                      w_emit, w_release, w_we0, w_we1;
  logic                      w_b_en_nxt, w_tile_nxt, w_drained_nxt;
  logic                      r_b_en, r_tile_start, r_drained;
  logic signed [BITS_AB-1:0] w_rd0 [DIM];
  logic signed [BITS_AB-1:0] w_rd1 [DIM];
  logic signed [BITS_AB-1:0] w_rd_data [DIM];
  logic signed [BITS_AB-1:0] r_b_out [DIM];

  assign w_in_ready  = ~r_full[r_fill_bank];
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_fill_done = w_accept && (r_wr_row == LAST_ROW);
  assign w_we0       = w_accept && (r_fill_bank == 1'b0);
  assign w_we1       = w_accept && (r_fill_bank == 1'b1);
  // A bank completing this edge counts as full now, so row 0 leaves on the same edge.
  assign w_rd_avail  = r_full[r_rd_bank] || (w_fill_done && (r_fill_bank == r_rd_bank));
  assign w_bypass    = w_fill_done && (r_fill_bank == r_rd_bank) && (r_rd_row == r_wr_row);

  memb_bank #(.BITS_AB(BITS_AB), .DIM(DIM)) u_bank0 (
    .clk       (clk),
    .i_we      (w_we0),
    .i_wr_row  (r_wr_row),
    .i_wr_data (bus.in_row),
    .i_rd_row  (r_rd_row),
    .o_rd_data (w_rd0)
  );

  memb_bank #(.BITS_AB(BITS_AB), .DIM(DIM)) u_bank1 (
    .clk       (clk),
    .i_we      (w_we1),
    .i_wr_row  (r_wr_row),
    .i_wr_data (bus.in_row),
    .i_rd_row  (r_rd_row),
    .o_rd_data (w_rd1)
  );

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      w_rd_data[i] = w_bypass ? bus.in_row[i] : (r_rd_bank ? w_rd1[i] : w_rd0[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_b_en_nxt      = 1'b0;
    w_tile_nxt      = 1'b0;
    w_drained_nxt   = 1'b0;
    w_emit          = 1'b0;
    w_release       = 1'b0;
    w_rd_row_nxt    = r_rd_row;
    w_flush_cnt_nxt = r_flush_cnt;
    if (w_rd_avail) begin
      w_state_nxt = ST_STREAM;
      w_emit      = 1'b1;
      w_b_en_nxt  = 1'b1;
      w_tile_nxt  = (r_rd_row == '0);
      if (r_rd_row == LAST_ROW) begin
        w_release    = 1'b1;
        w_rd_row_nxt = '0;
      end else begin
        w_rd_row_nxt = r_rd_row + ROW_W'(1);
      end
    end else begin
      case (r_state)
        ST_STREAM: begin
          w_state_nxt     = ST_FLUSH;
          w_b_en_nxt      = 1'b1;
          w_flush_cnt_nxt = FLUSH_RELOAD;
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            w_state_nxt   = ST_IDLE;
            w_drained_nxt = 1'b1;
          end else begin
            w_b_en_nxt      = 1'b1;
            w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_set_full = '0;
    w_clr_full = '0;
    if (w_fill_done) w_set_full[r_fill_bank] = 1'b1;
    if (w_release)   w_clr_full[r_rd_bank]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full       <= '0;
      r_fill_bank  <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_row     <= '0;
      r_rd_row     <= '0;
      r_flush_cnt  <= '0;
      r_b_en       <= 1'b0;
      r_tile_start <= 1'b0;
      r_drained    <= 1'b0;
      for (int i = 0; i < DIM; i++) r_b_out[i] <= '0;
    end else begin
      // Set and clear target different banks except when DIM is 1, where clear wins.
      r_full <= (r_full | w_set_full) & ~w_clr_full;
      if (w_accept)    r_wr_row    <= w_fill_done ? '0 : r_wr_row + ROW_W'(1);
      if (w_fill_done) r_fill_bank <= ~r_fill_bank;
      if (w_release)   r_rd_bank   <= ~r_rd_bank;
      r_rd_row     <= w_rd_row_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_b_en       <= w_b_en_nxt;
      r_tile_start <= w_tile_nxt;
      r_drained    <= w_drained_nxt;
      for (int i = 0; i < DIM; i++) r_b_out[i] <= w_emit ? w_rd_data[i] : '0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.b_out      = r_b_out;
  assign bus.b_en       = r_b_en;
  assign bus.tile_start = r_tile_start;
  assign bus.drained    = r_drained;
endmodule

// File: tb/tb_memb_loader.sv
// Scoreboard bench for memb_loader at DIM=4, BITS_AB=8: rows queued on acceptance, popped per streamed row.
module tb_memb_loader;
  localparam int BITS  = 8;
  localparam int DIM   = 4;
  localparam int FLUSH = 2 * DIM - 1;

  typedef logic signed [BITS-1:0] row_t [DIM];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memb_loader_if #(.BITS_AB(BITS), .DIM(DIM)) bus ();

  memb_loader #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int row_left = 0;
  int zero_run = 0;
  int en_cnt = 0;
  int drained_cnt = 0;
  int exp_drained = 0;
  int zero_at_start = 0;
  int acc_cyc = 0;
  logic [DIM*BITS-1:0] exp_q [$];
  int tile_cyc [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [DIM*BITS-1:0] pack(input row_t r);
    logic [DIM*BITS-1:0] p;
    for (int e = 0; e < DIM; e++) p[e*BITS +: BITS] = r[e];
    return p;
  endfunction

  function automatic row_t mk(input int base);
    row_t r;
    for (int e = 0; e < DIM; e++) r[e] = 8'(base + e);
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (bus.tile_start) begin
        check("tile_start_mid_tile", row_left, 0);
        row_left      = DIM;
        zero_at_start = zero_run;
        tile_cyc.push_back(cyc);
      end
      if (row_left > 0) begin
        check("b_en_row", bus.b_en, 1'b1);
        if (exp_q.size() == 0) check("scoreboard_nonempty", exp_q.size(), 1);
        else check("b_out_row", pack(bus.b_out), exp_q.pop_front());
        row_left--;
        zero_run = 0;
        en_cnt++;
      end else if (bus.b_en) begin
        check("b_out_flush_zero", pack(bus.b_out), '0);
        zero_run++;
        en_cnt++;
      end else begin
        check("b_out_idle_zero", pack(bus.b_out), '0);
      end
      if (bus.drained) begin
        check("flush_len", zero_run, FLUSH);
        check("drained_b_en", bus.b_en, 1'b0);
        drained_cnt++;
        zero_run = 0;
      end
    end
  end

  task automatic do_reset(input int cycles);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    row_left = 0;
    zero_run = 0;
    en_cnt   = 0;
    check("rst_b_en",       bus.b_en, 1'b0);
    check("rst_b_out",      pack(bus.b_out), '0);
    check("rst_tile_start", bus.tile_start, 1'b0);
    check("rst_drained",    bus.drained, 1'b0);
    check("rst_in_ready",   bus.in_ready, 1'b1);
    mon_en = 1'b1;
  endtask

  task automatic send_row(input row_t r);
    bit rdy;
    bit done;
    done = 1'b0;
    bus.in_row   = r;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        exp_q.push_back(pack(r));
        acc_cyc = cyc;
      end
    end
    if (!done) check("accept_timeout", done, 1'b1);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    exp_drained++;
    for (int k = 0; k < budget && drained_cnt < exp_drained; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drained_count", drained_cnt, exp_drained);
  endtask

  task automatic check_tiles(input string tag, input int n);
    check(tag, tile_cyc.size(), n);
    for (int t = 1; t < tile_cyc.size(); t++) check("tile_gap", tile_cyc[t] - tile_cyc[t-1], DIM);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t xr [4];
    bus.in_valid = 1'b0;
    bus.in_row   = mk(0);
    do_reset(3);

    // Single tile: rows in order, tile_start on the first, 7-cycle flush, row 0 right after last accept
    tile_cyc.delete(); en_cnt = 0;
    for (int k = 0; k < DIM; k++) send_row(mk(4 * k + 1));
    wait_drained(60);
    check_tiles("t1_tiles", 1);
    if (tile_cyc.size() > 0) check("t1_latency", tile_cyc[0], acc_cyc + 1);
    check("t1_en_cycles", en_cnt, DIM + FLUSH);

    // Two contiguous tiles stream with no gap and share one flush
    tile_cyc.delete(); en_cnt = 0;
    for (int k = 0; k < 2 * DIM; k++) send_row(mk(20 + 4 * k));
    wait_drained(80);
    check_tiles("t2_tiles", 2);
    check("t2_en_cycles", en_cnt, 2 * DIM + FLUSH);

    // Second tile completes during flush cycle 3: flush is cut short with no drained pulse
    tile_cyc.delete(); en_cnt = 0;
    for (int k = 0; k < DIM + 3; k++) send_row(mk(50 + 4 * k));
    for (int k = 0; k < 40 && zero_run < 2; k++) @(posedge clk);
    #1;
    send_row(mk(90));
    wait_drained(80);
    check("t3_tiles", tile_cyc.size(), 2);
    check("t3_zero_before_preempt", zero_at_start, 3);
    check("t3_en_cycles", en_cnt, 2 * DIM + 3 + FLUSH);

    // in_valid held through three tiles: nothing lost or duplicated
    tile_cyc.delete(); en_cnt = 0;
    for (int k = 0; k < 3 * DIM; k++) send_row(mk(4 * k - 40));
    wait_drained(120);
    check_tiles("t4_tiles", 3);
    check("t4_en_cycles", en_cnt, 3 * DIM + FLUSH);

    // Reset after two rows discards the partial tile; a fresh tile then streams cleanly
    send_row(mk(-100));
    send_row(mk(-96));
    do_reset(1);
    tile_cyc.delete();
    for (int k = 0; k < DIM; k++) send_row(mk(30 + 4 * k));
    wait_drained(60);
    check("t5_tiles", tile_cyc.size(), 1);
    check("t5_en_cycles", en_cnt, DIM + FLUSH);

    // Extreme signed values pass through bit-exact
    xr[0] = mk(0); xr[1] = mk(0); xr[2] = mk(0); xr[3] = mk(0);
    xr[0][0] = -8'sd128; xr[0][1] = 8'sd127;  xr[0][2] = -8'sd1;   xr[0][3] = 8'sd0;
    xr[1][0] = 8'sd127;  xr[1][1] = -8'sd128; xr[1][2] = 8'sd1;    xr[1][3] = -8'sd2;
    xr[2][0] = -8'sd128; xr[2][1] = -8'sd128; xr[2][2] = 8'sd127;  xr[2][3] = 8'sd127;
    xr[3][0] = 8'sd127;  xr[3][1] = 8'sd0;    xr[3][2] = -8'sd128; xr[3][3] = -8'sd1;
    tile_cyc.delete(); en_cnt = 0;
    for (int k = 0; k < DIM; k++) send_row(xr[k]);
    wait_drained(60);
    check("t6_tiles", tile_cyc.size(), 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
